serial_subtractor_param: RTL and testbench

SERIAL_SUBTRACTOR_PARAM -- requirements
Module: serial_subtractor_param

---
 rtl/serial_subtractor_param_if.sv | 24 ++
 rtl/serial_subtractor_param.sv | 90 +++++++++
 tb/tb_serial_subtractor_param.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_param_if.sv
// rtl/serial_subtractor_param_if.sv - operand/result bundle for the bit-serial subtractor
interface serial_subtractor_param_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         B_in;
    logic         busy;
    logic         done;
    logic [N-1:0] D;
    logic         B_out;
    logic         V;

    modport master (
        output start, A, B, B_in,
        input  busy, done, D, B_out, V
    );

    modport slave (
        input  start, A, B, B_in,
        output busy, done, D, B_out, V
    );
endinterface

// File: rtl/serial_subtractor_param.sv
// rtl/serial_subtractor_param.sv - bit-serial A - B - B_in, one bit per cycle, LSB first
module serial_subtractor_param #(
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_subtractor_param_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  res;
    logic          br;
    logic [CW-1:0] cnt;

    logic          a_bit;
    logic          b_bit;
    logic          d_bit;
    logic          br_next;
    logic          last;
    logic [N-1:0]  bit_mask;

    // Operands stay latched; the current bit is picked out by the counter.
    assign bit_mask = N'(1) << cnt;
    assign a_bit    = |(a_reg & bit_mask);
    assign b_bit    = |(b_reg & bit_mask);
    assign d_bit    = a_bit ^ b_bit ^ br;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    assign last     = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res       <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.D     <= '0;
            bus.B_out <= 1'b0;
            bus.V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg    <= bus.A;
                        b_reg    <= bus.B;
                        br       <= bus.B_in;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res <= {d_bit, res[N-1:1]};
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        // Signed overflow: borrow into the MSB differs from borrow out of it.
                        bus.D     <= {d_bit, res[N-1:1]};
                        bus.B_out <= br_next;
                        bus.V     <= br ^ br_next;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor_param.sv
// tb/tb_serial_subtractor_param.sv - model-checked directed bench for serial_subtractor_param
module tb_serial_subtractor_param;
    localparam int N = 4;

    logic clk;
    logic rst;

    serial_subtractor_param_if #(.N(N)) bus ();

    serial_subtractor_param #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: arithmetic result plus a cycles-remaining count.
    int           m_run;
    bit           m_done;
    logic [N-1:0] m_D, p_D;
    logic         m_Bo, p_Bo, m_V, p_V;
    int           cyc;

    function automatic void compute(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                                    output logic [N-1:0] d, output logic bo, output logic v);
        int diff, sa, sb, sd;
        diff = int'(a) - int'(b) - int'(bin);
        d    = diff[N-1:0];
        bo   = (diff < 0);
        sa   = (int'(a) >= (1 << (N - 1))) ? int'(a) - (1 << N) : int'(a);
        sb   = (int'(b) >= (1 << (N - 1))) ? int'(b) - (1 << N) : int'(b);
        sd   = sa - sb - int'(bin);
        v    = (sd > (1 << (N - 1)) - 1) || (sd < -(1 << (N - 1)));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_D = '0; m_Bo = 0; m_V = 0;
        end else begin
            if (m_done) begin
                m_done = 0;
            end else if (m_run > 0) begin
                m_run = m_run - 1;
                if (m_run == 0) begin
                    m_done = 1; m_D = p_D; m_Bo = p_Bo; m_V = p_V;
                end
            end else if (bus.start) begin
                compute(bus.A, bus.B, bus.B_in, p_D, p_Bo, p_V);
                m_run = N;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    int done_seen = 0;
    always @(negedge clk) begin
        n_cmp++;
        if (bus.busy !== (m_run > 0) || bus.done !== m_done || bus.D !== m_D ||
            bus.B_out !== m_Bo || bus.V !== m_V) begin
            n_err++;
            $display("FAIL cycle_check t=%0t got busy=%b done=%b D=%b Bo=%b V=%b want busy=%b done=%b D=%b Bo=%b V=%b",
                     $time, bus.busy, bus.done, bus.D, bus.B_out, bus.V,
                     (m_run > 0), m_done, m_D, m_Bo, m_V);
        end
        if (bus.done === 1'b1) done_seen++;
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done; return captured results.
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                      output logic [N-1:0] d, output logic bo, output logic v,
                      output int busy_cycles);
        bit got;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.B_in = bin; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        busy_cycles = 0; got = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin got = 1; break; end
            @(negedge clk);
        end
        check("done_timeout", int'(got), 1);
        d = bus.D; bo = bus.B_out; v = bus.V;
    endtask

    logic [N-1:0] d;
    logic         bo, v;
    int           bc, t1, t2, dcount;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.B_in = 1'b0;
        cyc = 0;
        #2;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_D", int'(bus.D), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op(4'b1011, 4'b1101, 1'b0, d, bo, v, bc);
        check("s31_D", int'(d), 4'b1110);
        check("s31_Bo", int'(bo), 1);
        check("s31_V", int'(v), 0);

        op(4'b0101, 4'b0011, 1'b0, d, bo, v, bc);
        check("s32_D", int'(d), 4'b0010);
        check("s32_Bo", int'(bo), 0);
        check("s32_busy_cycles", bc, N);

        op(4'b1001, 4'b0110, 1'b1, d, bo, v, bc);
        check("s33a_D", int'(d), 4'b0010);
        check("s33a_Bo", int'(bo), 0);
        check("s33a_V", int'(v), 1);
        op(4'b0111, 4'b1000, 1'b0, d, bo, v, bc);
        check("s33b_D", int'(d), 4'b1111);
        check("s33b_Bo", int'(bo), 1);
        check("s33b_V", int'(v), 1);
        op(4'b0000, 4'b0000, 1'b1, d, bo, v, bc);
        check("zero_minus_bin_D", int'(d), 4'b1111);
        op(4'b1000, 4'b0000, 1'b1, d, bo, v, bc);
        check("min_minus_one_V", int'(v), 1);

        // Operands and start disturbed during RUN and DONE.
        @(negedge clk);
        dcount = done_seen;
        bus.A = 4'b0110; bus.B = 4'b0001; bus.B_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.A = 4'b1111; bus.B = 4'b1010; bus.B_in = 1'b1;
        for (int i = 0; i < 30 && !bus.done; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("s34_one_done", done_seen - dcount, 1);
        check("s34_D", int'(bus.D), 4'b0101);

        // Reset mid-RUN after a result of 0010.
        op(4'b0101, 4'b0011, 1'b0, d, bo, v, bc);
        @(negedge clk);
        dcount = done_seen;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("s35_busy", int'(bus.busy), 0);
        check("s35_D", int'(bus.D), 0);
        check("s35_Bo", int'(bus.B_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("s35_no_done", done_seen - dcount, 0);
        op(4'b1100, 4'b0100, 1'b0, d, bo, v, bc);
        check("s35_after_D", int'(d), 4'b1000);

        // Start held high: back-to-back operations.
        @(negedge clk);
        bus.A = 4'b0011; bus.B = 4'b0001; bus.B_in = 1'b0; bus.start = 1'b1;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (t1 < 0) t1 = cyc; else t2 = cyc;
            end
        end
        bus.start = 1'b0;
        check("s36_spacing", t2 - t1, N + 2);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
